// File: rtl/wishbone_fifo_subordinate.sv
// wishbone_fifo_subordinate: Wishbone classic-cycle subordinate. Writes to DATA push
// 32-bit words into a circular FIFO drained by a valid/pop consumer; STATUS, CTRL and
// SCRATCH are bus-readable. Optional level interrupt enabled by `WB_FIFO_SUB_IRQ_EN.
module wishbone_fifo_subordinate #(
    parameter logic [31:0] BASE_ADDR   = 32'h3400_0000,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] usr_dat_o,
    output logic        usr_valid_o,
    input  logic        usr_pop_i,
    output logic        irq_o
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WCNT_W = 4;
    localparam logic [WCNT_W-1:0] WAIT_LOAD = (WAIT_STATES > 0) ? WCNT_W'(WAIT_STATES - 1) : '0;
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [1:0] OFF_DATA    = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_CTRL    = 2'd2;
    localparam logic [1:0] OFF_SCRATCH = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t              state, state_n;
    logic [WCNT_W-1:0]   wcnt, wcnt_n;
    logic                commit_c;

    logic                lat_we, lat_hit;
    logic [3:0]          lat_sel;
    logic [1:0]          lat_off;
    logic [31:0]         lat_dat;

    logic [31:0]         mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                ovf, unf, selerr;
    logic [31:0]         scratch;
    logic [7:0]          irq_level;

    logic                hit_c, txn_we_c, txn_hit_c;
    logic [3:0]          txn_sel_c;
    logic [1:0]          txn_off_c;
    logic [31:0]         txn_dat_c, rdata_c, status_c, ctrl_rd_c;
    logic                empty_c, full_c, wr_c, push_req_c, push_ok_c, ovf_set_c, selerr_set_c;
    logic                ctrl_wr_c, fifo_clr_c, flag_clr_c, scratch_wr_c, pop_ok_c, unf_set_c;
    logic                unused_adr_c;

    assign unused_adr_c = ^wbs_adr_i[1:0];

    // State register and wait-state counter
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= S_IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
        end
    end

    // Next state; commit_c marks the edge entering ACK, where side effects land
    always_comb begin
        state_n  = state;
        wcnt_n   = wcnt;
        commit_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    if (WAIT_STATES > 0) begin
                        state_n = S_WAIT;
                        wcnt_n  = WAIT_LOAD;
                    end else begin
                        state_n  = S_ACK;
                        commit_c = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (!wbs_cyc_i) begin
                    state_n = S_IDLE;
                end else if (wcnt == '0) begin
                    state_n  = S_ACK;
                    commit_c = 1'b1;
                end else begin
                    wcnt_n = wcnt - WCNT_W'(1);
                end
            end
            S_ACK:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Capture the request at accept so wait states need not hold the bus stable
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            lat_we  <= 1'b0;
            lat_hit <= 1'b0;
            lat_sel <= '0;
            lat_off <= '0;
            lat_dat <= '0;
        end else if (state == S_IDLE && wbs_cyc_i && wbs_stb_i) begin
            lat_we  <= wbs_we_i;
            lat_hit <= hit_c;
            lat_sel <= wbs_sel_i;
            lat_off <= wbs_adr_i[3:2];
            lat_dat <= wbs_dat_i;
        end
    end

    // Live inputs commit directly when there are no wait states
    assign hit_c     = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign txn_we_c  = (state == S_IDLE) ? wbs_we_i       : lat_we;
    assign txn_hit_c = (state == S_IDLE) ? hit_c          : lat_hit;
    assign txn_sel_c = (state == S_IDLE) ? wbs_sel_i      : lat_sel;
    assign txn_off_c = (state == S_IDLE) ? wbs_adr_i[3:2] : lat_off;
    assign txn_dat_c = (state == S_IDLE) ? wbs_dat_i      : lat_dat;

    assign empty_c      = (count == '0);
    assign full_c       = (count == FULL_CNT);
    assign wr_c         = commit_c && txn_hit_c && txn_we_c;
    assign push_req_c   = wr_c && (txn_off_c == OFF_DATA);
    assign push_ok_c    = push_req_c && (txn_sel_c == 4'hF) && !full_c;
    assign ovf_set_c    = push_req_c && (txn_sel_c == 4'hF) && full_c;
    assign selerr_set_c = push_req_c && (txn_sel_c != 4'hF);
    assign ctrl_wr_c    = wr_c && (txn_off_c == OFF_CTRL);
    assign fifo_clr_c   = ctrl_wr_c && txn_dat_c[0];
    assign flag_clr_c   = ctrl_wr_c && txn_dat_c[1];
    assign scratch_wr_c = wr_c && (txn_off_c == OFF_SCRATCH);
    assign pop_ok_c     = usr_pop_i && !empty_c && !fifo_clr_c;
    assign unf_set_c    = usr_pop_i && empty_c && !fifo_clr_c;

    assign status_c = {16'h0, 8'(count), 3'b0, selerr, unf, ovf, full_c, empty_c};
`ifdef WB_FIFO_SUB_IRQ_EN
    assign ctrl_rd_c = {16'h0, irq_level, 8'h0};
`else
    assign ctrl_rd_c = '0;
`endif

    // Read mux; misses and writes return zero
    always_comb begin
        rdata_c = '0;
        if (txn_hit_c && !txn_we_c) begin
            case (txn_off_c)
                OFF_STATUS:  rdata_c = status_c;
                OFF_CTRL:    rdata_c = ctrl_rd_c;
                OFF_SCRATCH: rdata_c = scratch;
                default:     rdata_c = '0;
            endcase
        end
    end

    // Bus response: one-cycle ACK with data held only during it
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= commit_c;
            wbs_dat_o <= commit_c ? rdata_c : '0;
        end
    end

    // FIFO storage, left unreset
    always_ff @(posedge wb_clk_i) begin
        if (push_ok_c) mem[wr_ptr] <= txn_dat_c;
    end

    // FIFO pointers and occupancy; clear overrides a concurrent pop
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || fifo_clr_c) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
        end
    end

    assign usr_valid_o = !empty_c;
    assign usr_dat_o   = usr_valid_o ? mem[rd_ptr] : '0;

    // Sticky error flags; a new event in the clearing cycle still registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ovf    <= 1'b0;
            unf    <= 1'b0;
            selerr <= 1'b0;
        end else begin
            ovf    <= (ovf    && !flag_clr_c) || ovf_set_c;
            unf    <= (unf    && !flag_clr_c) || unf_set_c;
            selerr <= (selerr && !flag_clr_c) || selerr_set_c;
        end
    end

    // Scratch register with per-lane byte enables
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            scratch <= '0;
        end else if (scratch_wr_c) begin
            for (int b = 0; b < 4; b++) begin
                if (txn_sel_c[b]) scratch[8*b +: 8] <= txn_dat_c[8*b +: 8];
            end
        end
    end

`ifdef WB_FIFO_SUB_IRQ_EN
    // Interrupt level and registered level/overflow interrupt
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_level <= '0;
            irq_o     <= 1'b0;
        end else begin
            if (ctrl_wr_c) irq_level <= txn_dat_c[15:8];
            irq_o <= ((irq_level != 8'h0) && (8'(count) >= irq_level)) || ovf;
        end
    end
`else
    assign irq_level = '0;
    assign irq_o     = 1'b0;
`endif

endmodule

// File: doc/wishbone_fifo_subordinate.md
Name: wishbone_fifo_subordinate

Overview:
- Wishbone classic-cycle subordinate (responder) sitting behind the wishbone_decoder peripheral slot; the counterpart of wishbone_manager.
- Bus writes to a DATA register push 32-bit words into an internal FIFO, which a user-side consumer drains with a valid/pop handshake.
- Status, control and scratch registers are bus-readable.
- Configurable wait states exercise the manager's BUSY/ACK handling.

Parameters:
- BASE_ADDR, 32'h3400_0000: base of the 16-byte register window; decode compares wbs_adr_i[31:4] against BASE_ADDR[31:4].
- DEPTH, 8: FIFO depth in words; power of two, 2..128.
- WAIT_STATES, 0: extra cycles between accept and ACK; 0..15.

Ports:
- wb_clk_i  in  1  sole clock, rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_stb_i  in  1  strobe.
- wbs_cyc_i  in  1  cycle.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge, one-cycle pulse.
- wbs_dat_o  out  32  read data, valid while wbs_ack_o=1.
- usr_dat_o  out  32  FIFO head word.
- usr_valid_o  out  1  FIFO not empty.
- usr_pop_i  in  1  consume head this cycle.
- irq_o  out  1  level-threshold interrupt (see Optional Feature).

Behaviour:
- Reset (synchronous on wb_rst_i=1):
  - FSM=IDLE; wbs_ack_o=0; wbs_dat_o=0.
  - FIFO empty, count=0, read/write pointers=0; usr_valid_o=0; usr_dat_o=0.
  - All sticky flags, CTRL and SCRATCH cleared; irq_o=0.
  - Reset asserted mid-transaction drops that transaction with no ACK and no side effect; the manager must reissue it.
- FSM states:
  - IDLE: accept when wbs_cyc_i & wbs_stb_i. Go to WAIT if WAIT_STATES>0, else ACK. Latch we, sel, adr[3:2], dat and hit at accept.
  - WAIT: down-counter loaded with WAIT_STATES-1; go to ACK when it reaches 0. If cyc drops during WAIT, abort to IDLE with no side effect and no ACK.
  - ACK: wbs_ack_o=1 for exactly this cycle, then IDLE. Side effects commit on the edge entering ACK; wbs_dat_o is registered on that same edge and returns to 0 when leaving ACK.
  - Latency, accept edge to ACK high: 1+WAIT_STATES cycles.
  - stb still high in the cycle after ACK starts a new transaction (back-to-back is legal).
- Address map, offset = adr[3:2]; adr[1:0] ignored:
  - 0 DATA:
    - Write pushes wbs_dat_i only when sel==4'hF and the FIFO is not full.
    - Write while full is dropped and sets OVF.
    - Write with partial sel is dropped and sets SELERR.
    - Read returns 0.
  - 1 STATUS (RO): [0] empty, [1] full, [2] OVF, [3] UNF, [4] SELERR, [15:8] count zero-extended, rest 0. Writes are ignored.
  - 2 CTRL:
    - [0] FIFO clear, write-1 self-clearing, reads 0.
    - [1] sticky-flag clear, write-1 self-clearing, reads 0.
    - [15:8] IRQ_LEVEL.
    - Other bits read 0.
  - 3 SCRATCH: RW; each byte lane is written only where its sel bit=1.
- Miss (adr[31:4] != BASE_ADDR[31:4]): still ACKed with the same latency, read data 0, no side effect. This prevents bus hangs.
- FIFO:
  - Circular buffer; pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
  - usr_dat_o = mem[rd_ptr] combinationally; usr_valid_o = (count != 0).
  - usr_pop_i while empty: ignored, sets UNF.
  - Push and pop committing on the same edge: both happen, count unchanged. Exception: when full, the push is rejected (OVF set) and the pop still happens.
  - FIFO clear and usr_pop_i on the same edge: clear wins, UNF not set.
- Sticky flags stay set until CTRL[1] is written as 1 or reset.

Optional Feature:
- Macro: WB_FIFO_SUB_IRQ_EN.
- Defined:
  - irq_o is registered: 1 when IRQ_LEVEL != 0 and count >= IRQ_LEVEL, or when OVF=1.
  - Updated every cycle; one-cycle lag after count changes.
- Undefined:
  - irq_o tied to 0.
  - CTRL[15:8] is not stored and reads 0.

Test Plan:
- Reset, then read STATUS at 0x3400_0004 -> ACK once, data 32'h0000_0001 (empty), usr_valid_o=0.
- Write 32'h1234_5678 to 0x3400_0000 with sel=F, WAIT_STATES=0 -> ACK 1 cycle after accept; usr_valid_o=1, usr_dat_o=32'h1234_5678, STATUS count field=1.
- Push 9 words 1..9 with DEPTH=8 ->
  - words 1..8 stored; STATUS = 32'h0000_0806 (count 8, full, OVF);
  - 8 usr_pop_i pulses yield 1..8 in order; pointers wrap; then empty.
- SCRATCH: write 32'hAABB_CCDD sel=F, then 32'h1122_3344 sel=4'b0101 -> read returns 32'hAA22_CC44.
- WAIT_STATES=3:
  - read a miss address 0x3500_0000 -> ACK 4 cycles after accept, data 0;
  - drop cyc during WAIT -> no ACK, no side effect;
  - assert wb_rst_i during WAIT -> no ACK, FIFO empty.
- With WB_FIFO_SUB_IRQ_EN: CTRL=32'h0000_0300, then push 3 words -> irq_o=1 one cycle after count reaches 3; one pop -> irq_o=0.
- Without WB_FIFO_SUB_IRQ_EN: the same sequence keeps irq_o=0, and a CTRL read returns 0.
